// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/stall controller for the 5-stage pipeline
// Pause holds a pipeline register and beats bubble; outputs are combinational from state and inputs.
module pipeline_ctrl #(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_mdu,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_pause,
  output logic             if_id_pause,
  output logic             if_id_bubble,
  output logic             id_ex_pause,
  output logic             id_ex_bubble,
  output logic             ex_mem_pause,
  output logic             ex_mem_bubble,
  output logic             mem_wb_pause,
  output logic             mem_wb_bubble,
  output logic             pc_redirect,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MW = $clog2(MDU_LAT + 1);
  localparam int WW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [MW-1:0] MDU_LOAD = MW'(MDU_LAT - 2);
  localparam logic [WW-1:0] TMO_VAL  = WW'(MEM_TIMEOUT);

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t          state, state_nx;
  logic [MW-1:0]   mdu_cnt, mdu_cnt_nx;
  logic [WW-1:0]   wait_cnt, wait_cnt_nx;
  logic            mem_wait, mem_stall, mdu_hold, load_use;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      mdu_cnt     <= '0;
      wait_cnt    <= '0;
      stall_count <= '0;
    end else begin
      state       <= state_nx;
      mdu_cnt     <= mdu_cnt_nx;
      wait_cnt    <= wait_cnt_nx;
      stall_count <= stall_count + CNT_W'(pc_pause);
    end
  end

  always_comb begin
    state_nx      = state;
    mdu_cnt_nx    = mdu_cnt;
    wait_cnt_nx   = '0;
    pc_pause      = 1'b0;
    if_id_pause   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_pause   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_pause  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_pause  = 1'b0;
    mem_wb_bubble = 1'b0;
    pc_redirect   = 1'b0;

    mdu_busy    = (state == MDU_BUSY);
    mem_wait    = mem_req & ~mem_ready;
    // Once the wait budget is spent the access is released as if ready arrived.
    mem_timeout = ~reset & mem_wait & (wait_cnt == TMO_VAL);
    mem_stall   = ~reset & mem_wait & ~mem_timeout;
    mdu_done    = ~reset & mdu_busy & (mdu_cnt == '0);
    mdu_hold    = ((state == RUN) & ex_is_mdu) | (mdu_busy & (mdu_cnt != '0));
    load_use    = ex_is_load & (ex_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    if (reset) begin
      if_id_bubble  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_pause      = 1'b1;
      if_id_pause   = 1'b1;
      id_ex_pause   = 1'b1;
      ex_mem_pause  = 1'b1;
      mem_wb_bubble = 1'b1;
      wait_cnt_nx   = wait_cnt + WW'(1);
      // The MDU keeps computing while memory stalls, so its countdown still runs.
      if (mdu_cnt != '0) mdu_cnt_nx = mdu_cnt - MW'(1);
    end else if (mdu_hold) begin
      pc_pause      = 1'b1;
      if_id_pause   = 1'b1;
      id_ex_pause   = 1'b1;
      ex_mem_bubble = 1'b1;
      if (state == RUN) begin
        state_nx   = MDU_BUSY;
        mdu_cnt_nx = MDU_LOAD;
      end else begin
        mdu_cnt_nx = mdu_cnt - MW'(1);
      end
    end else begin
      if (mdu_done) state_nx = RUN;
      if (ex_branch_taken) begin
        pc_redirect  = 1'b1;
        if_id_bubble = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_pause     = 1'b1;
        if_id_pause  = 1'b1;
        id_ex_bubble = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
// Reference model tracks MDU op age and consecutive memory wait cycles as plain integers.
module tb_pipeline_ctrl;
  localparam int MDU_LAT = 4;
  localparam int MEM_TMO = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_is_mdu, ex_branch_taken, mem_req, mem_ready;
  logic        pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble;
  logic        ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble;
  logic        pc_redirect, mdu_busy, mdu_done, mem_timeout;
  logic [31:0] stall_count;

  pipeline_ctrl #(.MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TMO), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_is_mdu(ex_is_mdu), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_pause(pc_pause),
    .if_id_pause(if_id_pause), .if_id_bubble(if_id_bubble), .id_ex_pause(id_ex_pause),
    .id_ex_bubble(id_ex_bubble), .ex_mem_pause(ex_mem_pause), .ex_mem_bubble(ex_mem_bubble),
    .mem_wb_pause(mem_wb_pause), .mem_wb_bubble(mem_wb_bubble), .pc_redirect(pc_redirect),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Bit order: pc_p, ifid_p, ifid_b, idex_p, idex_b, exmem_p, exmem_b, memwb_p, memwb_b, redir, busy, done, tmo
  logic [12:0] got_v, exp_v;
  int          m_age, m_wait;
  logic [31:0] m_sc;
  logic        m_mstall, m_done;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, load, branch;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    logic mem_wait, tmo, idle, hold, lu;
    exp_v = '0;
    idle  = (m_age == 0);
    exp_v[2] = !idle;
    if (reset) begin
      exp_v[10] = 1; exp_v[8] = 1; exp_v[6] = 1; exp_v[4] = 1;
      m_mstall = 0; m_done = 0;
      return;
    end
    mem_wait = mem_req && !mem_ready;
    tmo      = mem_wait && (m_wait == MEM_TMO);
    m_mstall = mem_wait && !tmo;
    m_done   = !idle && (m_age >= MDU_LAT - 1);
    hold     = (idle && ex_is_mdu) || (!idle && !m_done);
    lu       = ex_is_load && ex_rd != 0 &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    exp_v[1] = m_done;
    exp_v[0] = tmo;
    if (m_mstall) begin
      exp_v[12] = 1; exp_v[11] = 1; exp_v[9] = 1; exp_v[7] = 1; exp_v[4] = 1;
    end else if (hold) begin
      exp_v[12] = 1; exp_v[11] = 1; exp_v[9] = 1; exp_v[6] = 1;
    end else if (ex_branch_taken) begin
      exp_v[3] = 1; exp_v[10] = 1; exp_v[8] = 1;
    end else if (lu) begin
      exp_v[12] = 1; exp_v[11] = 1; exp_v[8] = 1;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_age = 0; m_wait = 0; m_sc = 0;
      return;
    end
    m_sc   = m_sc + 32'(exp_v[12]);
    m_wait = m_mstall ? m_wait + 1 : 0;
    if (m_mstall) begin
      if (m_age != 0 && m_age < MDU_LAT - 1) m_age++;
    end else if (m_age == 0) begin
      if (ex_is_mdu) m_age = 1;
    end else if (m_done) begin
      m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic step(input string tag);
    #1;
    model_eval();
    got_v = {pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble, ex_mem_pause,
             ex_mem_bubble, mem_wb_pause, mem_wb_bubble, pc_redirect, mdu_busy, mdu_done, mem_timeout};
    chk({tag, "_outs"}, 32'(got_v), 32'(exp_v));
    chk({tag, "_stall_count"}, stall_count, m_sc);
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_is_mdu = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    int n_p, n_b, n_t, done_at, sc0;
    m_age = 0; m_wait = 0; m_sc = 0;
    idle_inputs();
    reset = 1;
    @(negedge clock);
    step("reset0");
    chk("reset_bubbles", 32'(got_v), 32'(13'b0010101010000));
    step("reset1");
    reset = 0;

    // rs1, rs2, rd, use1, use2, load, branch, expected
    tbl[0] = '{5, 1, 5, 1, 0, 1, 0, 13'b1100100000000};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 13'b0000000000000};
    tbl[2] = '{0, 1, 0, 1, 1, 1, 0, 13'b0000000000000};
    tbl[3] = '{5, 1, 5, 0, 0, 1, 0, 13'b0000000000000};
    tbl[4] = '{5, 1, 5, 1, 0, 1, 1, 13'b0010100001000};
    tbl[5] = '{2, 7, 7, 0, 1, 1, 0, 13'b1100100000000};
    tbl[6] = '{7, 7, 7, 1, 1, 0, 0, 13'b0000000000000};
    tbl[7] = '{3, 4, 9, 1, 1, 0, 1, 13'b0010100001000};
    for (int i = 0; i < 8; i++) begin
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
      id_use_rs1 = tbl[i].use1; id_use_rs2 = tbl[i].use2;
      ex_is_load = tbl[i].load; ex_branch_taken = tbl[i].branch;
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_const", i), 32'(got_v), 32'(tbl[i].exp));
    end
    idle_inputs();

    // MDU op held in EX: 3 stalled cycles, done on the 4th, then the next op stalls again
    ex_is_mdu = 1; n_p = 0; n_b = 0; done_at = -1; sc0 = int'(stall_count);
    for (int i = 0; i < 4; i++) begin
      step("mdu");
      n_p += got_v[12]; n_b += got_v[6];
      if (got_v[1]) done_at = i;
    end
    chk("mdu_pauses", 32'(n_p), 32'd3);
    chk("mdu_exmem_bubbles", 32'(n_b), 32'd3);
    chk("mdu_done_cycle", 32'(done_at), 32'd3);
    chk("mdu_stall_delta", stall_count - 32'(sc0), 32'd3);
    step("mdu2");
    chk("mdu_restart_pause", 32'(got_v[12]), 32'd1);
    for (int i = 0; i < 3; i++) step("mdu2b");
    ex_is_mdu = 0;
    step("mdu_idle");

    // five memory wait cycles, well under the timeout
    mem_req = 1; mem_ready = 0; n_p = 0; n_b = 0; n_t = 0;
    for (int i = 0; i < 5; i++) begin
      step("mwait");
      n_p += got_v[7]; n_b += got_v[4]; n_t += got_v[0];
    end
    chk("mwait_pauses", 32'(n_p), 32'd5);
    chk("mwait_memwb_bubbles", 32'(n_b), 32'd5);
    chk("mwait_no_timeout", 32'(n_t), 32'd0);
    mem_ready = 1;
    step("mwait_rel");
    mem_req = 0;
    step("mwait_idle");

    // memory never ready: MEM_TMO stall cycles, one timeout pulse, then a fresh wait
    mem_req = 1; mem_ready = 0; n_p = 0; done_at = -1;
    for (int i = 0; i <= MEM_TMO; i++) begin
      step("tmo");
      n_p += got_v[12];
      if (got_v[0]) done_at = i;
    end
    chk("tmo_stalls", 32'(n_p), 32'(MEM_TMO));
    chk("tmo_pulse_cycle", 32'(done_at), 32'(MEM_TMO));
    step("tmo_after");
    chk("tmo_restall", 32'({got_v[12], got_v[0]}), 32'b10);
    mem_req = 0;
    step("tmo_idle");

    // memory stall across the end of an MDU op keeps mdu_done asserted
    ex_is_mdu = 1;
    step("mm_start");
    ex_is_mdu = 0; mem_req = 1; mem_ready = 0; n_t = 0;
    for (int i = 0; i < 5; i++) begin
      step("mm_stall");
      n_t += got_v[1];
    end
    chk("mm_done_while_stalled", 32'(n_t), 32'd3);
    mem_req = 0;
    step("mm_release");
    chk("mm_release_done", 32'({got_v[12], got_v[1]}), 32'b01);
    step("mm_idle");
    chk("mm_busy_clear", 32'(got_v[2]), 32'd0);

    // reset in the middle of an MDU op
    ex_is_mdu = 1;
    step("rm_start");
    step("rm_busy");
    reset = 1; ex_is_mdu = 0;
    step("rm_reset");
    reset = 0;
    step("rm_after");
    chk("rm_after_state", 32'({got_v[2], got_v[1], got_v[12]}), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_is_load      = ($urandom_range(0, 2) == 0);
      ex_is_mdu       = ($urandom_range(0, 4) == 0);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req         = ($urandom_range(0, 2) != 0);
      mem_ready       = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
